// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding for the program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    // States in which the loader is consuming stream words.
    function automatic logic is_rx_state(input state_t s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/prog_loader_counter.sv
// rtl/prog_loader_counter.sv - instruction address counter with clear and increment
// Ports: clk, rst (sync, active-high), clr (zero the count), inc (count up, wraps),
//        count (current address).
module counter #(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [BIT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + BIT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed program stream to instruction RAM writer
// Ports: clk, rst (sync, active-high), start (begin a load),
//        in_data/in_valid/in_ready (stream handshake),
//        mem_we/mem_addr/mem_data (instruction RAM write port),
//        cpu_rst (core held in reset unless a good load completed),
//        done (good load), err (bad length or checksum).
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int INST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [INST_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [INST_WIDTH-1:0] mem_data,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   remaining;
    logic [INST_WIDTH-1:0]   checksum;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    accept;
    logic                    len_ok;
    logic                    addr_clr;
    logic                    addr_inc;

    assign accept   = in_valid & in_ready;
    // Length word may only carry a value that fits the address space.
    assign len_ok   = ((in_data >> ADDR_WIDTH) == '0);
    assign addr_clr = (state == S_LEN) && accept && len_ok;
    assign addr_inc = (state == S_DATA) && accept;

    counter #(
        .BIT_WIDTH (ADDR_WIDTH)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (addr_clr),
        .inc   (addr_inc),
        .count (addr)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nx = S_LEN;
            S_LEN:   if (accept) state_nx = len_ok ? S_DATA : S_ERROR;
            S_DATA:  if (accept && (remaining == '0)) state_nx = S_CHECK;
            S_CHECK: if (accept) state_nx = (in_data == checksum) ? S_DONE : S_ERROR;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            checksum  <= '0;
            remaining <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= is_rx_state(state_nx);
            cpu_rst  <= (state_nx != S_DONE);
            done     <= (state_nx == S_DONE);
            err      <= (state_nx == S_ERROR);
            mem_we   <= 1'b0;

            if (addr_clr) begin
                remaining <= in_data[ADDR_WIDTH-1:0];
                checksum  <= '0;
            end

            if (addr_inc) begin
                mem_we   <= 1'b1;
                mem_addr <= addr;
                mem_data <= in_data;
                checksum <= checksum ^ in_data;
                if (remaining != '0) begin
                    remaining <= remaining - ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_rst;
    logic       done;
    logic       err;

    int vectors;
    int miscompares;

    logic [7:0]  frame[$];
    logic [11:0] exp_w[$];
    logic [11:0] got_q[$];
    bit          exp_done;
    int          n_acc;

    prog_loader #(
        .ADDR_WIDTH (4),
        .INST_WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_q.push_back({mem_addr, mem_data});
            check("cpu_rst_during_write", {31'd0, cpu_rst}, 32'd1);
        end
    end

    // Reference: a frame is length L, then L+1 words, then their XOR.
    // Lengths above the address space are rejected after one word.
    task automatic build_expect();
        logic [7:0] x;
        int         n;
        exp_w.delete();
        if (frame[0] > 8'd15) begin
            exp_done = 1'b0;
            n_acc    = 1;
        end else begin
            n = int'(frame[0]) + 1;
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                exp_w.push_back({4'(i % 16), frame[1 + i]});
                x ^= frame[1 + i];
            end
            exp_done = (frame[n + 1] == x);
            n_acc    = n + 2;
        end
    endtask

    // Called between posedge+1 and the next posedge, where in_ready is stable.
    task automatic send_word(input logic [7:0] w, input bit gaps);
        bit acc;
        int guard;
        guard   = 0;
        in_data = w;
        forever begin
            in_valid = (gaps && ($urandom_range(0, 2) != 0)) ? 1'b0 : 1'b1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            guard++;
            if (guard > 200) begin
                miscompares++;
                $error("FAIL accept_timeout observed=%0d expected=accept", guard);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input bit gaps, input bit hold_start);
        got_q.delete();
        build_expect();
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        @(negedge clk);
        check({name, "_len_ready"}, {31'd0, in_ready}, 32'd1);
        check({name, "_len_err"},   {31'd0, err},      32'd0);
        check({name, "_len_done"},  {31'd0, done},     32'd0);
        check({name, "_len_cpurst"},{31'd0, cpu_rst},  32'd1);
        for (int i = 0; i < n_acc; i++) begin
            send_word(frame[i], gaps);
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_nwrites"}, got_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++) begin
            if (i < got_q.size()) check({name, "_write"}, {20'd0, got_q[i]}, {20'd0, exp_w[i]});
        end
        check({name, "_done"},    {31'd0, done},     {31'd0, exp_done});
        check({name, "_err"},     {31'd0, err},      {31'd0, !exp_done});
        check({name, "_cpu_rst"}, {31'd0, cpu_rst},  {31'd0, !exp_done});
        check({name, "_ready"},   {31'd0, in_ready}, 32'd0);
        check({name, "_we_idle"}, {31'd0, mem_we},   32'd0);
    endtask

    task automatic random_frame();
        int         len;
        logic [7:0] x;
        logic [7:0] w;
        frame.delete();
        if ($urandom_range(0, 5) == 0) begin
            frame.push_back(8'($urandom_range(16, 255)));
        end else begin
            len = $urandom_range(0, 15);
            frame.push_back(8'(len));
            x = 8'h00;
            for (int i = 0; i <= len; i++) begin
                w = 8'($urandom);
                frame.push_back(w);
                x ^= w;
            end
            if ($urandom_range(0, 2) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            frame.push_back(x);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we",   {31'd0, mem_we},   32'd0);
        check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check("rst_mem_data", {24'd0, mem_data}, 32'd0);
        check("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_err",      {31'd0, err},      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        frame = '{8'h02, 8'h11, 8'h22, 8'h44, 8'h77};
        run_frame("basic", 1'b0, 1'b0);

        frame = '{8'h02, 8'h11, 8'h22, 8'h44, 8'h76};
        run_frame("badsum", 1'b0, 1'b0);

        frame = '{8'h02, 8'h11, 8'h22, 8'h44, 8'h77};
        run_frame("retry", 1'b0, 1'b0);

        frame.delete();
        frame.push_back(8'h0F);
        for (int i = 0; i < 16; i++) frame.push_back(8'(i));
        frame.push_back(8'h00);
        run_frame("full", 1'b0, 1'b0);

        frame = '{8'h13};
        run_frame("badlen", 1'b0, 1'b0);

        frame = '{8'h02, 8'h11, 8'h22, 8'h44, 8'h77};
        run_frame("gaps", 1'b1, 1'b0);

        frame = '{8'h02, 8'h11, 8'h22, 8'h44, 8'h77};
        run_frame("hold_start", 1'b0, 1'b1);

        // Reset after the second data word.
        got_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_word(8'h02, 1'b0);
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_mem_we",   {31'd0, mem_we},   32'd0);
        check("midrst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check("midrst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("midrst_done",     {31'd0, done},     32'd0);
        check("midrst_err",      {31'd0, err},      32'd0);
        in_valid = 1'b1;
        in_data  = 8'h44;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("midrst_nwrites", got_q.size(), 32'd2);
        if (got_q.size() >= 2) begin
            check("midrst_w0", {20'd0, got_q[0]}, {20'd0, 4'h0, 8'h11});
            check("midrst_w1", {20'd0, got_q[1]}, {20'd0, 4'h1, 8'h22});
        end

        for (int k = 0; k < 10; k++) begin
            random_frame();
            run_frame("rand", ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
